// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 stream core: FSM states, hash/working
// variable types, round constants, initial hash values and the FIPS 180-4
// logical functions.
package sha256_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_e;

  // {H0..H7}, H0 is element 0 (most significant word).
  typedef logic [0:7][31:0] hash_t;

  // Working variables; field a lands in the top word so a cast from hash_t
  // maps H0->a ... H7->h.
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  localparam hash_t IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam hash_t IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic hash_t init_hash(input logic sha224);
    return sha224 ? IV224 : IV256;
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Ports: wv_i  - working variables a..h before the round
//        k_i   - round constant K_t
//        w_i   - schedule word W_t
//        wv_o  - working variables after the round
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       wv_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output work_t       wv_o
);

  logic [31:0] t1, t2;

  always_comb begin
    t1     = wv_i.h + big_sigma1(wv_i.e) + ch(wv_i.e, wv_i.f, wv_i.g) + k_i + w_i;
    t2     = big_sigma0(wv_i.a) + maj(wv_i.a, wv_i.b, wv_i.c);
    wv_o.a = t1 + t2;
    wv_o.b = wv_i.a;
    wv_o.c = wv_i.b;
    wv_o.d = wv_i.c;
    wv_o.e = wv_i.d + t1;
    wv_o.f = wv_i.e;
    wv_o.g = wv_i.f;
    wv_o.h = wv_i.g;
  end

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 compression engine. Takes padded 512-bit blocks over a
// valid/ready handshake, chains H across blocks and holds the final digest
// until the consumer takes it. UNROLL (1,2,4,8) rounds are evaluated per clock.
// Ports: clk, reset (sync, active high)
//        blk_valid/blk_ready/blk_data/blk_first/blk_last - block input
//        digest_valid/digest_ready/digest                - digest output {H0..H7}
//        busy                                            - not IDLE
// Optional: define SHA224_EN to add the blk_mode input (1 = SHA-224 IV and a
// truncated digest with the low word zeroed).
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
`ifdef SHA224_EN
  input  logic         blk_mode,
`endif
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_stream_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);
  localparam logic [5:0] STEP     = 6'(UNROLL);

  typedef logic [0:15][31:0] window_t;  // element 0 is W_t

  // Slide the window by UNROLL words, appending freshly expanded words.
  // Later expansions see earlier ones, so the chain is exact for any UNROLL.
  function automatic window_t next_window(input window_t w);
    logic [31:0] nw;
    for (int k = 0; k < UNROLL; k++) begin
      nw = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
      w  = {w[1:15], nw};
    end
    return w;
  endfunction

  state_e       state_q, state_d;
  hash_t        h_q, h_d;
  work_t        wv_q, wv_d;
  window_t      w_q, w_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         last_q, last_d;
  logic [255:0] digest_q, digest_d;
  logic         digest_valid_q, digest_valid_d;
  logic         blk_ready_q, blk_ready_d;
  logic         busy_q, busy_d;
`ifdef SHA224_EN
  logic         mode_q, mode_d;
`endif

  // Round chain: stage j consumes W_{t+j} = w_q[j] and K_{t+j}.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    work_t wv_in, wv_out;
    if (j == 0) begin : g_head
      assign wv_in = wv_q;
    end else begin : g_link
      assign wv_in = g_rnd[j-1].wv_out;
    end
    sha256_round u_round (
      .wv_i (wv_in),
      .k_i  (K[cnt_q + 6'(j)]),
      .w_i  (w_q[j]),
      .wv_o (wv_out)
    );
  end

  work_t rnd_out;
  assign rnd_out = g_rnd[UNROLL-1].wv_out;

  hash_t h_new;
  hash_t wv_words;
  hash_t iv_sel;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    wv_d     = wv_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    digest_d = digest_q;
`ifdef SHA224_EN
    mode_d   = mode_q;
    iv_sel   = init_hash(blk_mode);
`else
    iv_sel   = init_hash(1'b0);
`endif

    wv_words = hash_t'(wv_q);
    for (int i = 0; i < 8; i++) h_new[i] = h_q[i] + wv_words[i];

    case (state_q)
      S_IDLE: begin
        if (blk_valid) begin
          w_d    = window_t'(blk_data);
          last_d = blk_last;
          cnt_d  = '0;
          if (blk_first) begin
            h_d  = iv_sel;
            wv_d = work_t'(iv_sel);
`ifdef SHA224_EN
            mode_d = blk_mode;
`endif
          end else begin
            wv_d = work_t'(h_q);
          end
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        wv_d  = rnd_out;
        w_d   = next_window(w_q);
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST_CNT) state_d = S_FINAL;
      end
      S_FINAL: begin
        h_d = h_new;
        if (last_q) begin
`ifdef SHA224_EN
          digest_d = mode_q ? {h_new[0:6], 32'h0} : h_new;
`else
          digest_d = h_new;
`endif
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (digest_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake/status outputs are registered from the next state.
    blk_ready_d    = (state_d == S_IDLE);
    digest_valid_d = (state_d == S_DONE);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      h_q            <= IV256;
      wv_q           <= '0;
      w_q            <= '0;
      cnt_q          <= '0;
      last_q         <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      blk_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
`ifdef SHA224_EN
      mode_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      wv_q           <= wv_d;
      w_q            <= w_d;
      cnt_q          <= cnt_d;
      last_q         <= last_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      blk_ready_q    <= blk_ready_d;
      busy_q         <= busy_d;
`ifdef SHA224_EN
      mode_q         <= mode_d;
`endif
    end
  end

  assign blk_ready    = blk_ready_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench for sha256_stream_core: one UNROLL=1 and one UNROLL=4
// instance. Stimulus pushes expected {digest, latency}; monitors pop on each
// rising digest_valid and compare.
module tb_sha256_stream_core;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2    = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DG    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DG  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DG    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         blk_valid, blk_ready, blk_first, blk_last, digest_valid, digest_ready, busy;
  logic [511:0] blk_data;
  logic [255:0] digest;
  logic         blk_valid4, blk_ready4, blk_first4, blk_last4, digest_valid4, digest_ready4, busy4;
  logic [511:0] blk_data4;
  logic [255:0] digest4;
`ifdef SHA224_EN
  logic         blk_mode, blk_mode4;
`endif

  sha256_stream_core #(.UNROLL(1)) dut (
    .clk(clk), .reset(reset), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last),
`ifdef SHA224_EN
    .blk_mode(blk_mode),
`endif
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest), .busy(busy));

  sha256_stream_core #(.UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .blk_valid(blk_valid4), .blk_ready(blk_ready4),
    .blk_data(blk_data4), .blk_first(blk_first4), .blk_last(blk_last4),
`ifdef SHA224_EN
    .blk_mode(blk_mode4),
`endif
    .digest_valid(digest_valid4), .digest_ready(digest_ready4), .digest(digest4), .busy(busy4));

  typedef struct {
    logic [255:0] dg;
    int           lat;
  } exp_t;

  exp_t sb[$], sb4[$];
  int   acc[$], acc4[$];
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  task automatic check_dg(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge counter and accept-edge log for last blocks (latency reference).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      acc.delete();
      acc4.delete();
    end else begin
      if (blk_valid && blk_ready && blk_last) acc.push_back(cyc);
      if (blk_valid4 && blk_ready4 && blk_last4) acc4.push_back(cyc);
    end
  end

  logic dv_prev = 1'b0, dv4_prev = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    if (digest_valid && !dv_prev) begin
      if (sb.size() == 0) check_int("unexpected_digest_u1", 1, 0);
      else begin
        e   = sb.pop_front();
        lat = (acc.size() != 0) ? (cyc - 1 - acc.pop_front()) : -1;
        check_dg("digest_u1", digest, e.dg);
        check_int("latency_u1", lat, e.lat);
      end
    end
    if (digest_valid4 && !dv4_prev) begin
      if (sb4.size() == 0) check_int("unexpected_digest_u4", 1, 0);
      else begin
        e   = sb4.pop_front();
        lat = (acc4.size() != 0) ? (cyc - 1 - acc4.pop_front()) : -1;
        check_dg("digest_u4", digest4, e.dg);
        check_int("latency_u4", lat, e.lat);
      end
    end
    dv_prev  <= digest_valid;
    dv4_prev <= digest_valid4;
  end

  // Present a block, hold it until accepted; returns the accepting edge index.
  task automatic send(input bit four, input logic [511:0] d, input logic first, input logic last,
                      output int edge_idx);
    int t = 0;
    @(negedge clk);
    if (four) begin
      blk_data4 = d; blk_first4 = first; blk_last4 = last; blk_valid4 = 1'b1;
    end else begin
      blk_data = d; blk_first = first; blk_last = last; blk_valid = 1'b1;
    end
    while (!(four ? blk_ready4 : blk_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!(four ? blk_ready4 : blk_ready)) begin
      check_int("accept_timeout", t, 0);
      edge_idx = -1;
    end else begin
      edge_idx = cyc;
      @(posedge clk);
    end
    #1;
    if (four) blk_valid4 = 1'b0;
    else      blk_valid  = 1'b0;
  endtask

  task automatic wait_dv(input bit four);
    int t = 0;
    while (!(four ? digest_valid4 : digest_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!(four ? digest_valid4 : digest_valid)) check_int("digest_timeout", t, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2;
    reset = 1'b1;
    blk_valid = 0; blk_first = 0; blk_last = 0; blk_data = '0; digest_ready = 1'b1;
    blk_valid4 = 0; blk_first4 = 0; blk_last4 = 0; blk_data4 = '0; digest_ready4 = 1'b1;
`ifdef SHA224_EN
    blk_mode = 1'b0; blk_mode4 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_blk_ready", int'(blk_ready), 1);
    check_int("reset_digest_valid", int'(digest_valid), 0);
    check_int("reset_busy", int'(busy), 0);
    check_dg("reset_digest", digest, '0);
    check_int("reset_blk_ready_u4", int'(blk_ready4), 1);
    reset = 1'b0;

    // "abc", single block, UNROLL=1
    sb.push_back('{ABC_DG, 65});
    send(0, ABC_BLK, 1, 1, e1);
    @(negedge clk);
    check_int("busy_in_round", int'(busy), 1);
    check_int("ready_low_in_round", int'(blk_ready), 0);
    wait_dv(0);
    @(negedge clk);
    check_int("done_one_cycle_valid", int'(digest_valid), 0);
    check_int("done_one_cycle_ready", int'(blk_ready), 1);
    check_dg("digest_held_after_retire", digest, ABC_DG);

    // empty message, UNROLL=4
    sb4.push_back('{EMPTY_DG, 17});
    send(1, EMPTY_BLK, 1, 1, e1);
    wait_dv(1);
    @(negedge clk);

    // two-block message; second block presented during ROUND of the first
    sb.push_back('{TWO_DG, 65});
    send(0, TWO_B1, 1, 0, e1);
    send(0, TWO_B2, 0, 1, e2);
    check_int("block_spacing", e2 - e1, 66);
    wait_dv(0);
    @(negedge clk);

    // backpressure: digest held for 20 cycles
    digest_ready = 1'b0;
    sb.push_back('{ABC_DG, 65});
    send(0, ABC_BLK, 1, 1, e1);
    wait_dv(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_int("bp_valid", int'(digest_valid), 1);
      check_int("bp_blk_ready", int'(blk_ready), 0);
      check_dg("bp_digest_stable", digest, ABC_DG);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    check_int("bp_retire_valid", int'(digest_valid), 0);
    check_int("bp_retire_ready", int'(blk_ready), 1);
    check_dg("bp_retire_digest", digest, ABC_DG);

    // reset mid-ROUND aborts; next block hashes cleanly
    send(0, ABC_BLK, 1, 1, e1);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_int("abort_blk_ready", int'(blk_ready), 1);
    check_int("abort_digest_valid", int'(digest_valid), 0);
    check_int("abort_busy", int'(busy), 0);
    check_dg("abort_digest", digest, '0);
    sb.push_back('{ABC_DG, 65});
    send(0, ABC_BLK, 1, 1, e1);
    wait_dv(0);
    @(negedge clk);

`ifdef SHA224_EN
    blk_mode = 1'b1;
    sb.push_back('{{224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0}, 65});
    send(0, ABC_BLK, 1, 1, e1);
    wait_dv(0);
    @(negedge clk);
    blk_mode = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check_int("scoreboard_drained", sb.size() + sb4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
